// File: rtl/ysyx_23060201_pkg.sv
// Shared definitions for the writeback arbiter slice.
// Requester indices, requester count and round-robin pointer width, plus a
// helper that advances a requester index modulo the requester count.
package ysyx_23060201_pkg;

  // Requester count (NREQ); the arbiter only supports three requesters.
  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned PTR_W   = 2;

  typedef enum logic [PTR_W-1:0] {
    REQ_ALU = 2'd0,
    REQ_LSU = 2'd1,
    REQ_CSR = 2'd2
  } req_idx_e;

  // (idx + 1) mod 3
  function automatic req_idx_e rr_next(input req_idx_e idx);
    case (idx)
      REQ_ALU: return REQ_LSU;
      REQ_LSU: return REQ_CSR;
      default: return REQ_ALU;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060201_rr_arb.sv
// Three-way round-robin arbiter.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   valid     : per-requester request
//   grant     : one-hot grant (combinational, all-zero during reset)
//   gnt_idx   : index of the granted requester (meaningful when gnt_any)
//   gnt_any   : a grant is issued this cycle
// The pointer holds the highest-priority requester; after a grant it moves
// to the requester just past the winner, and holds when nothing is valid.
module ysyx_23060201_rr_arb
  import ysyx_23060201_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output req_idx_e           gnt_idx,
  output logic               gnt_any
);

  req_idx_e ptr_q;
  req_idx_e ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= REQ_ALU;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    req_idx_e cand;
    grant   = '0;
    gnt_idx = REQ_ALU;
    gnt_any = 1'b0;
    ptr_d   = ptr_q;
    cand    = ptr_q;
    // Scan ptr, ptr+1, ptr+2 (mod 3); first valid requester wins.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_any && valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
      cand = rr_next(cand);
    end
    if (rst) gnt_any = 1'b0;
    if (gnt_any) begin
      grant[gnt_idx] = 1'b1;
      ptr_d          = rr_next(gnt_idx);
    end
  end

endmodule

// File: rtl/ysyx_23060201_wb_arbiter.sv
// Writeback arbiter with register scoreboard.
// Three requesters (ALU, LSU, CSR) compete round-robin for a single register
// file write port; the winning rd/data is registered onto gpr_w* one cycle
// later. A busy-bit scoreboard tracks outstanding destinations: issue sets a
// bit, commit clears it, and set wins over clear on the same index.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   req_valid/req_rd/req_data    : packed per-requester writeback requests
//   req_ready                    : one-hot grant
//   gpr_wen/gpr_waddr/gpr_wdata  : registered register-file write port
//   issue_valid/issue_rd         : instruction issue marking rd busy
//   rs1, rs2                     : source indices to check
//   hazard1/hazard2/waw_hazard   : combinational scoreboard hits
//   busy_vec                     : scoreboard state
//   sb_err                       : sticky protocol-error flag
module ysyx_23060201_wb_arbiter
  import ysyx_23060201_pkg::*;
#(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int NREQ           = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ*GPR_ADDR_WIDTH-1:0] req_rd,
  input  logic [NREQ*DATA_WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]                req_ready,
  output logic                           gpr_wen,
  output logic [GPR_ADDR_WIDTH-1:0]      gpr_waddr,
  output logic [DATA_WIDTH-1:0]          gpr_wdata,
  input  logic                           issue_valid,
  input  logic [GPR_ADDR_WIDTH-1:0]      issue_rd,
  input  logic [GPR_ADDR_WIDTH-1:0]      rs1,
  input  logic [GPR_ADDR_WIDTH-1:0]      rs2,
  output logic                           hazard1,
  output logic                           hazard2,
  output logic                           waw_hazard,
  output logic [2**GPR_ADDR_WIDTH-1:0]   busy_vec,
  output logic                           sb_err
);

  localparam int unsigned NREG = 2**GPR_ADDR_WIDTH;

  req_idx_e                  gnt_idx;
  logic                      gnt_any;
  logic [GPR_ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic                      commit_nz;
  logic                      issue_nz;
  logic [NREG-1:0]           busy_q;
  logic [NREG-1:0]           set_vec;
  logic [NREG-1:0]           clr_vec;
  logic                      err_hit;

  ysyx_23060201_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_valid),
    .grant   (req_ready),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign sel_rd    = req_rd[int'(gnt_idx)*GPR_ADDR_WIDTH +: GPR_ADDR_WIDTH];
  assign sel_data  = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign commit_nz = gnt_any && (sel_rd != '0);
  assign issue_nz  = issue_valid && (issue_rd != '0);

  assign hazard1    = busy_q[rs1] && (rs1 != '0);
  assign hazard2    = busy_q[rs2] && (rs2 != '0);
  // Uses the registered bits, so a same-cycle commit does not hide it.
  assign waw_hazard = issue_nz && busy_q[issue_rd];
  assign busy_vec   = busy_q;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_nz)  set_vec[issue_rd] = 1'b1;
    if (commit_nz) clr_vec[sel_rd]   = 1'b1;
  end

  assign err_hit = (commit_nz && !busy_q[sel_rd]) || (issue_valid && waw_hazard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      sb_err <= 1'b0;
    end else begin
      busy_q <= (busy_q & ~clr_vec) | set_vec;
      if (err_hit) sb_err <= 1'b1;
    end
  end

  // rd=0 grants are accepted and latched but never write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else if (gnt_any) begin
      gpr_wen   <= (sel_rd != '0);
      gpr_waddr <= sel_rd;
      gpr_wdata <= sel_data;
    end else begin
      gpr_wen   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_wb_arbiter.sv
module tb_ysyx_23060201_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard1;
  logic        hazard2;
  logic        waw_hazard;
  logic [31:0] busy_vec;
  logic        sb_err;

  int n_checks = 0;
  int n_pass   = 0;

  ysyx_23060201_wb_arbiter #(
    .GPR_ADDR_WIDTH (5),
    .DATA_WIDTH     (32),
    .NREQ           (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .gpr_wen     (gpr_wen),
    .gpr_waddr   (gpr_waddr),
    .gpr_wdata   (gpr_wdata),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .hazard1     (hazard1),
    .hazard2     (hazard2),
    .waw_hazard  (waw_hazard),
    .busy_vec    (busy_vec),
    .sb_err      (sb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Behavioural model: priority list starting at m_ptr, busy bits as a plain set.
  int          m_ptr   = 0;
  bit [31:0]   m_busy  = '0;
  bit          m_wen   = 1'b0;
  bit [4:0]    m_waddr = '0;
  bit [31:0]   m_wdata = '0;
  bit          m_err   = 1'b0;

  function automatic int mgrant();
    if (rst) return -1;
    for (int k = 0; k < 3; k++) begin
      int i = (m_ptr + k) % 3;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int        g;
    bit [4:0]  rd;
    bit [31:0] nb;
    if (rst) begin
      m_ptr   <= 0;
      m_busy  <= '0;
      m_wen   <= 1'b0;
      m_waddr <= '0;
      m_wdata <= '0;
      m_err   <= 1'b0;
    end else begin
      g  = mgrant();
      nb = m_busy;
      if (g >= 0) begin
        rd = req_rd[g*5 +: 5];
        m_ptr   <= (g + 1) % 3;
        m_wen   <= (rd != 0);
        m_waddr <= rd;
        m_wdata <= req_data[g*32 +: 32];
        if (rd != 0) begin
          if (!m_busy[rd]) m_err <= 1'b1;
          nb[rd] = 1'b0;
        end
      end else begin
        m_wen <= 1'b0;
      end
      if (issue_valid && issue_rd != 0) begin
        if (m_busy[issue_rd]) m_err <= 1'b1;
        nb[issue_rd] = 1'b1;
      end
      m_busy <= nb;
    end
  end

  always @(negedge clk) begin : compare
    int        g;
    bit [2:0]  er;
    g  = mgrant();
    er = (g >= 0) ? (3'b001 << g) : 3'b000;
    chk("ready",    req_ready,  er);
    chk("hazard1",  hazard1,    m_busy[rs1] && rs1 != 0);
    chk("hazard2",  hazard2,    m_busy[rs2] && rs2 != 0);
    chk("waw",      waw_hazard, issue_valid && issue_rd != 0 && m_busy[issue_rd]);
    chk("busy_vec", busy_vec,   m_busy);
    chk("gpr_wen",  gpr_wen,    m_wen);
    chk("gpr_waddr",gpr_waddr,  m_waddr);
    chk("gpr_wdata",gpr_wdata,  m_wdata);
    chk("sb_err",   sb_err,     m_err);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  bit [31:0] exp_data  [6] = '{32'hA0000000, 32'hA0000101, 32'hA0000202,
                               32'hA0000003, 32'hA0000104, 32'hA0000205};
  bit [2:0]  exp_ready [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    rst = 1'b1; req_valid = 3'b111; req_rd = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1 = 5'd5; rs2 = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_ready", req_ready, 3'b000);
    chk("lit_rst_wen",   gpr_wen,   1'b0);
    chk("lit_rst_busy",  busy_vec,  32'h0);
    step();
    rst = 1'b0; req_valid = '0;

    // Issue rd=5, then ALU commits rd=5.
    issue_valid = 1'b1; issue_rd = 5'd5;
    step();
    issue_valid = 1'b0;
    req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd5}; req_data = {32'h0, 32'h0, 32'hDEADBEEF};
    @(negedge clk);
    chk("lit_alu_ready", req_ready,   3'b001);
    chk("lit_busy5_set", busy_vec[5], 1'b1);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("lit_wen",       gpr_wen,     1'b1);
    chk("lit_waddr",     gpr_waddr,   5'd5);
    chk("lit_wdata",     gpr_wdata,   32'hDEADBEEF);
    chk("lit_busy5_clr", busy_vec[5], 1'b0);

    // CSR request with rd=0; also returns ptr to 0.
    step();
    req_valid = 3'b100; req_rd = '0; req_data = {32'h1234, 32'h0, 32'h0};
    @(negedge clk);
    chk("lit_rd0_ready", req_ready, 3'b100);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("lit_rd0_wen",   gpr_wen,  1'b0);
    chk("lit_rd0_busy",  busy_vec, 32'h0);
    chk("lit_rd0_err",   sb_err,   1'b0);

    // Mark rd 1..6 busy, then all three requesters contend for 6 cycles.
    for (int r = 1; r <= 6; r++) begin
      step();
      issue_valid = 1'b1; issue_rd = 5'(r);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      issue_valid = 1'b0;
      req_valid = 3'b111;
      for (int i = 0; i < 3; i++) begin
        req_rd[i*5 +: 5]    = 5'(c + 1);
        req_data[i*32 +: 32] = 32'hA0000000 | 32'(i << 8) | 32'(c);
      end
      @(negedge clk);
      if (c == 0) chk("lit_busy_pre", busy_vec, 32'h0000007E);
      chk("lit_rr_ready", req_ready, exp_ready[c]);
      if (c > 0) begin
        chk("lit_rr_wdata", gpr_wdata, exp_data[c-1]);
        chk("lit_rr_waddr", gpr_waddr, 5'(c));
      end
    end
    step();
    req_valid = '0;
    @(negedge clk);
    chk("lit_rr_wdata_last", gpr_wdata, exp_data[5]);
    chk("lit_rr_busy_done",  busy_vec,  32'h0);

    // Commit rd=9 that was never issued: sticky error.
    step();
    req_valid = 3'b010; req_rd = {5'd0, 5'd9, 5'd0}; req_data = {32'h0, 32'h99, 32'h0};
    @(negedge clk);
    chk("lit_lsu_ready", req_ready, 3'b010);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("lit_err_set",  sb_err,    1'b1);
    chk("lit_err_addr", gpr_waddr, 5'd9);
    repeat (3) step();
    @(negedge clk);
    chk("lit_err_sticky", sb_err, 1'b1);

    // Same-cycle issue and commit of rd=7: set wins.
    step();
    issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
    req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd7}; req_data = {32'h0, 32'h0, 32'h77};
    @(negedge clk);
    chk("lit_waw_clear", waw_hazard, 1'b0);
    step();
    issue_valid = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("lit_busy7",    busy_vec[7], 1'b1);
    chk("lit_haz1_rs7", hazard1,     1'b1);
    #1 rs1 = 5'd0;
    #1 chk("lit_haz1_rs0", hazard1, 1'b0);
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1 chk("lit_waw_set", waw_hazard, 1'b1);

    // Mid-stream reset with busy bits and a pending write.
    step();
    issue_valid = 1'b1; issue_rd = 5'd3;
    req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd7}; req_data = {32'h0, 32'h0, 32'h55};
    step();
    issue_valid = 1'b0; req_valid = 3'b111; req_rd = '0;
    @(negedge clk);
    chk("lit_pre_rst_wen",  gpr_wen,     1'b1);
    chk("lit_pre_rst_busy", busy_vec[3], 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("lit_mid_rst_wen",   gpr_wen,   1'b0);
    chk("lit_mid_rst_waddr", gpr_waddr, 5'd0);
    chk("lit_mid_rst_wdata", gpr_wdata, 32'h0);
    chk("lit_mid_rst_busy",  busy_vec,  32'h0);
    chk("lit_mid_rst_err",   sb_err,    1'b0);
    chk("lit_mid_rst_ready", req_ready, 3'b000);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_post_rst_ready", req_ready, 3'b001);
    step();
    req_valid = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060201_wb_arbiter.md
YSYX_23060201_WB_ARBITER -- requirements
Module: ysyx_23060201_wb_arbiter

Interface
REQ-001 SHALL have parameter GPR_ADDR_WIDTH, default 5, GPR index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, writeback data width.
REQ-003 SHALL have parameter NREQ, default 3, requester count (0=ALU, 1=LSU, 2=CSR); only 3 is supported.
REQ-004 SHALL have port clk  input  1  sole clock, all state on posedge; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester writeback valid.
REQ-007 SHALL have port req_rd  input  NREQ*GPR_ADDR_WIDTH  packed destination index, requester i at slice i.
REQ-008 SHALL have port req_data  input  NREQ*DATA_WIDTH  packed writeback data, requester i at slice i.
REQ-009 SHALL have port req_ready  output  NREQ  one-hot grant, combinational.
REQ-010 SHALL have port gpr_wen  output  1  registered write enable to the register file.
REQ-011 SHALL have port gpr_waddr  output  GPR_ADDR_WIDTH  registered write index.
REQ-012 SHALL have port gpr_wdata  output  DATA_WIDTH  registered write data.
REQ-013 SHALL have port issue_valid  input  1  an instruction writing issue_rd is issued this cycle.
REQ-014 SHALL have port issue_rd  input  GPR_ADDR_WIDTH  destination of the issued instruction.
REQ-015 SHALL have port rs1, rs2  input  GPR_ADDR_WIDTH each  source indices to check.
REQ-016 SHALL have port hazard1, hazard2, waw_hazard  output  1 each  combinational scoreboard hits.
REQ-017 SHALL have port busy_vec  output  2**GPR_ADDR_WIDTH  scoreboard state.
REQ-018 SHALL have port sb_err  output  1  sticky protocol-error flag.

Function
REQ-019 Arbiter SHALL be round-robin: a 2-bit pointer ptr (0..2) holds highest priority, descending ptr, ptr+1, ptr+2 mod 3.
REQ-020 When a requester is granted, ptr SHALL become (granted+1) mod 3 at the next posedge; with no valid request ptr SHALL hold.
REQ-021 Exactly one req_ready bit SHALL be high per cycle when any req_valid is high, and none otherwise; a transfer completes on valid&ready.
REQ-022 Latency SHALL be 1 cycle: the granted rd/data appear on gpr_waddr/gpr_wdata with gpr_wen=1 after the next posedge; without a grant gpr_wen=0 and waddr/wdata hold.
REQ-023 A granted request with rd=0 SHALL be accepted (ready=1) but produce gpr_wen=0.
REQ-024 issue_valid with issue_rd!=0 SHALL set busy_vec[issue_rd] at the next posedge; issue_rd=0 SHALL never set a bit.
REQ-025 A grant with rd!=0 SHALL clear busy_vec[rd] at the next posedge (same edge gpr_wen rises).
REQ-026 Simultaneous set and clear of the same index SHALL leave the bit set.
REQ-027 hazard1 SHALL equal busy_vec[rs1] and (rs1!=0); hazard2 likewise for rs2.
REQ-028 waw_hazard SHALL equal issue_valid and busy_vec[issue_rd] and (issue_rd!=0), evaluated before any same-cycle clear.
REQ-029 sb_err SHALL set and stay set when a grant commits rd!=0 whose busy bit is 0, or when issue_valid occurs while waw_hazard=1.

Reset
REQ-030 rst SHALL asynchronously force ptr=0, busy_vec=0, gpr_wen=0, gpr_waddr=0, gpr_wdata=0, sb_err=0.
REQ-031 req_ready SHALL be all-zero while rst is high; a transaction in flight when rst asserts is dropped.

Structure
REQ-032 Requester indices, NREQ and the ptr width SHALL live in shared package ysyx_23060201_pkg.
REQ-033 The round-robin grant logic SHALL be the sub-module ysyx_23060201_rr_arb; the scoreboard stays in the top level.

Verification
REQ-034 Issue rd=5, then ALU req rd=5 data=0xDEADBEEF -> ready[0]=1; next cycle gpr_wen=1, waddr=5, wdata=0xDEADBEEF, busy_vec[5]=0.
REQ-035 All three valid for 6 cycles, ptr=0 at start -> grants 0,1,2,0,1,2; each granted data appears exactly one cycle later.
REQ-036 Req rd=0 data=0x1234 -> ready=1, gpr_wen=0 next cycle, busy_vec unchanged, sb_err=0.
REQ-037 Issue rd=7 and commit rd=7 on the same cycle -> busy_vec[7]=1 afterwards; hazard1=1 with rs1=7, hazard1=0 with rs1=0.
REQ-038 Commit rd=9 with busy_vec[9]=0 -> sb_err=1 and remains 1 until rst.
REQ-039 Assert rst mid-stream with busy bits and gpr_wen set -> all outputs zero immediately, ptr=0 on release.
